// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher controller: one inverse round per clock, round
// keys fetched combinationally from an external expanded-key store, with a
// valid/ready handshake on both the ciphertext and the plaintext side.
module aes_inv_cipher_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam logic [3:0] NR4  = 4'(NR);
  localparam logic [3:0] NRM1 = 4'(NR - 1);

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Byte 4*c+r is row r of column c; InvShiftRows rotates row r right by r.
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         last);
    logic [0:15][7:0] sb, kb, tb, ob;
    logic [3:0]       src, dst, base;
    sb = s;
    kb = k;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src     = 4'(4 * ((c + 4 - r) % 4) + r);
        dst     = 4'(4 * c + r);
        tb[dst] = ISBOX[sb[src]] ^ kb[dst];
      end
    end
    ob = tb;
    if (!last) begin
      for (int unsigned c = 0; c < 4; c++) begin
        base = 4'(4 * c);
        ob[base]        = mule(tb[base]) ^ mulb(tb[base+4'd1]) ^ muld(tb[base+4'd2]) ^ mul9(tb[base+4'd3]);
        ob[base + 4'd1] = mul9(tb[base]) ^ mule(tb[base+4'd1]) ^ mulb(tb[base+4'd2]) ^ muld(tb[base+4'd3]);
        ob[base + 4'd2] = muld(tb[base]) ^ mul9(tb[base+4'd1]) ^ mule(tb[base+4'd2]) ^ mulb(tb[base+4'd3]);
        ob[base + 4'd3] = mulb(tb[base]) ^ muld(tb[base+4'd1]) ^ mul9(tb[base+4'd2]) ^ mule(tb[base+4'd3]);
      end
    end
    return ob;
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [3:0]     round_q, round_d;
  logic           armed_q;

  // State, datapath and round registers; armed_q holds off in_ready until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      round_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      round_q <= round_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state and datapath update: initial key add on accept, one inverse round per ROUND cycle.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          st_d    = ciphertext ^ rk_data;
          round_d = NRM1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d = inv_round(st_q, rk_data, round_q == 4'd0);
        if (round_q == 4'd0) state_d = S_DONE;
        else                 round_d = round_q - 4'd1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state and round counter.
  always_comb begin
    in_ready  = armed_q && (state_q == S_IDLE);
    rk_addr   = (state_q == S_IDLE) ? NR4 : round_q;
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_ROUND) || (state_q == S_DONE);
    plaintext = st_q;
    round     = round_q;
  end

endmodule
